// File: rtl/xtea_keystream_gen.sv
// xtea_keystream_gen
// Counter-mode XTEA keystream generator. Encrypts {nonce, counter} with the
// latched 128-bit key and serves each 64-bit block as OUT_BYTES-wide beats
// over a valid/ready handshake. A one-block buffer lets the engine compute
// the next block while the current one drains.
//
// Optional build macro: XTEA_KS_UNROLL2_EN (two rounds per clock; same output).
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset (wins over start)
//   key       128-bit key, word k = key[32*k +: 32]; sampled on start
//   nonce     32-bit nonce; sampled on start
//   start     one-cycle pulse: latch key/nonce, counter=0, flush, begin
//   ks_ready  consumer accepts the beat when ks_valid && ks_ready
//   ks_valid  ks_data holds a valid beat
//   ks_data   current beat (beat 0 = LSBs of v1)
//   busy      engine is computing a block
//   ks_wrap   sticky: counter wrapped 0xFFFFFFFF -> 0
module xtea_keystream_gen #(
  parameter int unsigned ROUNDS    = 32,
  parameter int unsigned OUT_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [127:0]           key,
  input  logic [31:0]            nonce,
  input  logic                   start,
  input  logic                   ks_ready,
  output logic                   ks_valid,
  output logic [8*OUT_BYTES-1:0] ks_data,
  output logic                   busy,
  output logic                   ks_wrap
);

  localparam int unsigned W     = 8 * OUT_BYTES;
  localparam int unsigned BEATS = 8 / OUT_BYTES;
  localparam logic [31:0] DELTA = 32'h9E3779B9;
`ifdef XTEA_KS_UNROLL2_EN
  localparam int unsigned STEP  = 2;
`else
  localparam int unsigned STEP  = 1;
`endif

  typedef enum logic [1:0] {ENG_IDLE, ENG_CALC, ENG_DONE} eng_t;
  typedef enum logic       {BUF_EMPTY, BUF_FULL}          buf_t;

  eng_t         eng, eng_next;
  buf_t         buf_st, buf_next;

  logic [127:0] key_r;
  logic [31:0]  nonce_r;
  logic [31:0]  counter;
  logic [31:0]  v0, v1, sum;
  logic [6:0]   rnd;
  logic [63:0]  blk;
  logic [2:0]   idx;

  logic [95:0]  step;
  logic         rnd_last;
  logic         accept;
  logic         last_accept;
  logic         load;

  // One full XTEA round; returns {v0', v1', sum'}.
  function automatic logic [95:0] xtea_round(input logic [31:0]  a0,
                                             input logic [31:0]  a1,
                                             input logic [31:0]  s,
                                             input logic [127:0] k);
    logic [31:0] n0, n1, sn;
    n0 = a0 + ((((a1 << 4) ^ (a1 >> 5)) + a1) ^ (s + k[{s[1:0], 5'd0} +: 32]));
    sn = s + DELTA;
    n1 = a1 + ((((n0 << 4) ^ (n0 >> 5)) + n0) ^ (sn + k[{sn[12:11], 5'd0} +: 32]));
    return {n0, n1, sn};
  endfunction

`ifdef XTEA_KS_UNROLL2_EN
  logic [95:0] step1;
  always_comb begin
    step1 = xtea_round(v0, v1, sum, key_r);
    step  = xtea_round(step1[95:64], step1[63:32], step1[31:0], key_r);
  end
`else
  always_comb begin
    step = xtea_round(v0, v1, sum, key_r);
  end
`endif

  assign rnd_last    = (rnd == 7'(ROUNDS - STEP));
  assign accept      = (buf_st == BUF_FULL) && ks_ready;
  assign last_accept = accept && (idx == 3'(BEATS - 1));
  // Loading on the same cycle the last beat leaves keeps blocks back-to-back.
  assign load        = (eng == ENG_DONE) && ((buf_st == BUF_EMPTY) || last_accept);

  // Engine FSM
  always_comb begin
    eng_next = eng;
    case (eng)
      ENG_IDLE: eng_next = ENG_IDLE;
      ENG_CALC: if (rnd_last) eng_next = ENG_DONE;
      ENG_DONE: if (load)     eng_next = ENG_CALC;
      default:  eng_next = ENG_IDLE;
    endcase
    if (start) eng_next = ENG_CALC;
  end

  // Buffer FSM
  always_comb begin
    buf_next = buf_st;
    if (load)             buf_next = BUF_FULL;
    else if (last_accept) buf_next = BUF_EMPTY;
    if (start)            buf_next = BUF_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng    <= ENG_IDLE;
      buf_st <= BUF_EMPTY;
    end else begin
      eng    <= eng_next;
      buf_st <= buf_next;
    end
  end

  // Engine datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r   <= '0;
      nonce_r <= '0;
      counter <= '0;
      ks_wrap <= 1'b0;
      v0      <= '0;
      v1      <= '0;
      sum     <= '0;
      rnd     <= '0;
    end else if (start) begin
      key_r   <= key;
      nonce_r <= nonce;
      counter <= '0;
      ks_wrap <= 1'b0;
      v0      <= nonce;
      v1      <= '0;
      sum     <= '0;
      rnd     <= '0;
    end else if (eng == ENG_CALC) begin
      v0  <= step[95:64];
      v1  <= step[63:32];
      sum <= step[31:0];
      rnd <= rnd + 7'(STEP);
    end else if (load) begin
      counter <= counter + 32'd1;
      if (&counter) ks_wrap <= 1'b1;
      v0      <= nonce_r;
      v1      <= counter + 32'd1;
      sum     <= '0;
      rnd     <= '0;
    end
  end

  // Block buffer datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= '0;
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (load) begin
      blk <= {v0, v1};
      idx <= '0;
    end else if (accept) begin
      idx <= (idx == 3'(BEATS - 1)) ? 3'd0 : idx + 3'd1;
    end
  end

  assign ks_valid = (buf_st == BUF_FULL);
  assign ks_data  = blk[W*idx +: W];
  assign busy     = (eng == ENG_CALC);

endmodule

// File: tb/tb_xtea_keystream_gen.sv
// tb_xtea_keystream_gen
// Scoreboard bench for xtea_keystream_gen. dut: ROUNDS=32, OUT_BYTES=1.
// dut2: ROUNDS=2, OUT_BYTES=2, ks_ready held high, used for back-to-back blocks.
module tb_xtea_keystream_gen;

  localparam int unsigned ROUNDS = 32;
`ifdef XTEA_KS_UNROLL2_EN
  localparam int unsigned LAT = ROUNDS / 2 + 2;
`else
  localparam int unsigned LAT = ROUNDS + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic [31:0]  nonce = '0;
  logic         start = 1'b0;
  logic         ks_ready = 1'b0;
  logic         ks_valid;
  logic [7:0]   ks_data;
  logic         busy;
  logic         ks_wrap;

  logic         start2 = 1'b0;
  logic         rdy2 = 1'b1;
  logic         valid2;
  logic [15:0]  data2;
  logic         busy2;
  logic         wrap2;

  int checks = 0;
  int failures = 0;

  logic [7:0]   exp_q[$];
  logic [127:0] m_key;
  logic [31:0]  m_nonce;
  logic [31:0]  exp_ctr;
  bit           mon_en = 1'b0;
  bit           mon_req = 1'b0;
  int           beats_seen = 0;

  always #5 clk = ~clk;

  xtea_keystream_gen #(.ROUNDS(ROUNDS), .OUT_BYTES(1)) dut (
    .clk(clk), .rst(rst), .key(key), .nonce(nonce), .start(start),
    .ks_ready(ks_ready), .ks_valid(ks_valid), .ks_data(ks_data),
    .busy(busy), .ks_wrap(ks_wrap)
  );

  xtea_keystream_gen #(.ROUNDS(2), .OUT_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .key(key), .nonce(nonce), .start(start2),
    .ks_ready(rdy2), .ks_valid(valid2), .ks_data(data2),
    .busy(busy2), .ks_wrap(wrap2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] xtea_block(input logic [127:0] k, input logic [31:0] n,
                                             input logic [31:0] c, input int unsigned rounds);
    logic [31:0] a, b, s;
    a = n; b = c; s = 32'd0;
    for (int unsigned r = 0; r < rounds; r++) begin
      a = a + ((((b << 4) ^ (b >> 5)) + b) ^ (s + k[32*s[1:0] +: 32]));
      s = s + 32'h9E3779B9;
      b = b + ((((a << 4) ^ (a >> 5)) + a) ^ (s + k[32*s[12:11] +: 32]));
    end
    return {a, b};
  endfunction

  task automatic push_block();
    logic [63:0] blk;
    blk = xtea_block(m_key, m_nonce, exp_ctr, ROUNDS);
    for (int unsigned i = 0; i < 8; i++) exp_q.push_back(blk[8*i +: 8]);
    exp_ctr = exp_ctr + 32'd1;
  endtask

  // Scoreboard consumer: compares every accepted beat in order.
  always @(negedge clk) begin
    if (mon_en && ks_valid && ks_ready) begin
      if (exp_q.size() == 0) push_block();
      check("beat", {56'd0, ks_data}, {56'd0, exp_q.pop_front()});
      beats_seen++;
    end
  end

  // Leaves the caller one cycle after the start cycle, scoreboard reloaded.
  task automatic start_pulse(input logic [127:0] k, input logic [31:0] n);
    @(posedge clk); #1;
    key = k; nonce = n; start = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete();
    m_key = k; m_nonce = n; exp_ctr = 32'd0;
    push_block();
    mon_en = mon_req;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int target;
    bit ok;
    target = beats_seen + n;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (beats_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  vec [8];
    logic [63:0] b2;
    int          c;
    bit          seen;
    int          bad;

    vec = '{8'hd9, 8'h1e, 8'h13, 8'hf7, 8'hd8, 8'hd4, 8'he9, 8'hde};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out", {52'd0, ks_valid, ks_data, busy, ks_wrap, valid2}, 64'd0);

    // Back-to-back blocks on dut2 (ROUNDS=2, 16-bit beats)
    @(posedge clk); #1;
    key = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0; nonce = 32'h1234abcd; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid2) begin seen = 1'b1; break; end
    end
    check("d2_first_valid", {63'd0, seen}, 64'd1);
    for (int unsigned j = 0; j < 12; j++) begin
      if (j != 0) @(negedge clk);
      b2 = xtea_block(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 32'h1234abcd, 32'(j / 4), 2);
      check("d2_nogap", {63'd0, valid2}, 64'd1);
      check("d2_beat", {48'd0, data2}, {48'd0, b2[16*(j%4) +: 16]});
    end

    // Known-answer vector, latency and busy window
    mon_req = 1'b0;
    ks_ready = 1'b1;
    start_pulse('0, '0);
    c = 1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c == 1)       check("busy_first", {63'd0, busy}, 64'd1);
      if (c == LAT - 2) check("busy_last", {63'd0, busy}, 64'd1);
      if (c == LAT - 1) check("busy_off", {63'd0, busy}, 64'd0);
      if (ks_valid) begin seen = 1'b1; break; end
      c++;
    end
    check("first_valid_cycle", 64'(seen ? c : -1), 64'(LAT));
    for (int unsigned i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      check("kat_beat", {55'd0, ks_valid, ks_data}, {55'd0, 1'b1, vec[i]});
    end

    // Stall for 100 cycles after first valid; key change without start ignored
    mon_req = 1'b1;
    ks_ready = 1'b0;
    start_pulse(128'hdeadbeef_01234567_89abcdef_cafef00d, 32'h00c0ffee);
    key = ~key; nonce = ~nonce;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ks_valid) begin seen = 1'b1; break; end
    end
    check("stall_valid", {63'd0, seen}, 64'd1);
    for (int i = 0; i < 100; i++) begin
      check("stall_hold", {55'd0, ks_valid, ks_data}, {55'd0, 1'b1, exp_q[0]});
      @(negedge clk);
    end
    check("stall_busy_off", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 ks_ready = 1'b1;
    wait_beats(24, "stall_release");

    // Restart during CALC of block 3
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dut.counter == 32'd3 && busy) begin seen = 1'b1; break; end
    end
    check("reach_block3", {63'd0, seen}, 64'd1);
    start_pulse(128'h11112222_33334444_55556666_77778888, 32'hfeedface);
    @(negedge clk);
    check("restart_flush", {63'd0, ks_valid}, 64'd0);
    wait_beats(32, "restart_stream");

    // Counter wrap
    start_pulse(128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 32'h00000077);
    repeat (5) @(negedge clk);
    check("wrap_pre", {62'd0, busy, ks_wrap}, 64'h2);
    dut.counter = 32'hFFFFFFFF;
    exp_ctr = 32'd0;
    wait_beats(16, "wrap_stream");
    check("wrap_set", {63'd0, ks_wrap}, 64'd1);
    start_pulse(128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 32'h00000078);
    @(negedge clk);
    check("wrap_clr", {63'd0, ks_wrap}, 64'd0);

    // rst together with start mid-stream
    wait_beats(10, "pre_rst_stream");
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_out", {53'd0, ks_valid, ks_data, busy, ks_wrap}, 64'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ks_valid || busy) bad++;
    end
    check("rst_quiet", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
